// File: rtl/mrd_src_pack_p4.sv
// Serial-to-parallel packer: buffers one complex packet of up to MAX_BEATS*4 samples,
// then replays it downstream as 4-sample beats once the sink reports ready.
module mrd_src_pack_p4 #(
    parameter int wDATA     = 18,
    parameter int MAX_BEATS = 300
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [wDATA-1:0] in_real,
    input  logic [wDATA-1:0] in_imag,
    input  logic [11:0]      in_dftpts,
    input  logic [5:0]       in_size,
    output logic             in_ready,
    input  logic             sink_ready,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic [wDATA-1:0] out_real [0:3],
    output logic [wDATA-1:0] out_imag [0:3],
    output logic [11:0]      out_dftpts,
    output logic [5:0]       out_size,
    output logic             err
);

    localparam int MAX_PTS = MAX_BEATS * 4;
    localparam int IDX_W   = $clog2(MAX_PTS);
    localparam int BEAT_W  = $clog2(MAX_BEATS);

    typedef enum logic [1:0] {IDLE, FILL, WAIT_RDY, SEND} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [11:0]         dftpts_r;
    logic [5:0]          size_r;
    logic [BEAT_W-1:0]   rd_beat;
    logic [BEAT_W-1:0]   last_beat;
    logic                issuing;
    logic                hdr_legal;
    logic                at_last;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;

    logic                p_valid;
    logic                p_sop;
    logic                p_eop;
    logic [wDATA-1:0]    rd_re [0:3];
    logic [wDATA-1:0]    rd_im [0:3];

    logic [wDATA-1:0]    mem_re [0:3][0:MAX_BEATS-1];
    logic [wDATA-1:0]    mem_im [0:3][0:MAX_BEATS-1];

    assign hdr_legal = (in_dftpts >= 12'd12) && (in_dftpts <= 12'(MAX_PTS))
                       && ((in_dftpts % 12'd12) == 12'd0);
    assign at_last   = (12'(idx) == (dftpts_r - 12'd1));
    assign last_beat = BEAT_W'(dftpts_r[11:2] - 10'd1);

    // Samples of packets later discarded may land in the buffer; harmless, since
    // only a completed packet is ever read back.
    assign wr_en  = in_valid && (((state == IDLE) && in_sop) || (state == FILL));
    assign wr_idx = in_sop ? '0 : idx;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re[wr_idx[1:0]][wr_idx[IDX_W-1:2]] <= in_real;
            mem_im[wr_idx[1:0]][wr_idx[IDX_W-1:2]] <= in_imag;
        end
        for (int k = 0; k < 4; k++) begin
            rd_re[k] <= mem_re[k][rd_beat];
            rd_im[k] <= mem_im[k][rd_beat];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            err        <= 1'b0;
            idx        <= '0;
            dftpts_r   <= '0;
            size_r     <= '0;
            rd_beat    <= '0;
            issuing    <= 1'b0;
            out_dftpts <= '0;
            out_size   <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_sop) begin
                        if (!hdr_legal || in_eop) begin
                            err <= 1'b1;
                        end else begin
                            state    <= FILL;
                            idx      <= IDX_W'(1);
                            dftpts_r <= in_dftpts;
                            size_r   <= in_size;
                        end
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        if (in_sop) begin
                            err <= 1'b1;
                            if (hdr_legal && !in_eop) begin
                                idx      <= IDX_W'(1);
                                dftpts_r <= in_dftpts;
                                size_r   <= in_size;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (at_last) begin
                            if (in_eop) begin
                                state    <= WAIT_RDY;
                                in_ready <= 1'b0;
                            end else begin
                                err   <= 1'b1;
                                state <= IDLE;
                            end
                        end else if (in_eop) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                WAIT_RDY: begin
                    if (sink_ready) begin
                        state      <= SEND;
                        rd_beat    <= '0;
                        issuing    <= 1'b1;
                        out_dftpts <= dftpts_r;
                        out_size   <= size_r;
                    end
                end
                SEND: begin
                    if (issuing) begin
                        if (rd_beat == last_beat) begin
                            issuing <= 1'b0;
                        end else begin
                            rd_beat <= rd_beat + BEAT_W'(1);
                        end
                    end
                    // Hold off upstream until the final beat is actually on the outputs.
                    if (out_valid && out_eop) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid   <= 1'b0;
            p_sop     <= 1'b0;
            p_eop     <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                out_real[k] <= '0;
                out_imag[k] <= '0;
            end
        end else begin
            p_valid   <= (state == SEND) && issuing;
            p_sop     <= (state == SEND) && issuing && (rd_beat == '0);
            p_eop     <= (state == SEND) && issuing && (rd_beat == last_beat);
            out_valid <= p_valid;
            out_sop   <= p_sop;
            out_eop   <= p_eop;
            for (int k = 0; k < 4; k++) begin
                out_real[k] <= p_valid ? rd_re[k] : '0;
                out_imag[k] <= p_valid ? rd_im[k] : '0;
            end
        end
    end

endmodule

// File: tb/tb_mrd_src_pack_p4.sv
// Directed bench for mrd_src_pack_p4: drives packets, captures output beats and
// compares them against sample values the bench generated itself.
module tb_mrd_src_pack_p4;

    localparam int W = 18;

    logic          clk;
    logic          rst_n;
    logic          in_valid, in_sop, in_eop;
    logic [W-1:0]  in_real, in_imag;
    logic [11:0]   in_dftpts;
    logic [5:0]    in_size;
    logic          in_ready;
    logic          sink_ready;
    logic          out_valid, out_sop, out_eop;
    logic [W-1:0]  out_real [0:3];
    logic [W-1:0]  out_imag [0:3];
    logic [11:0]   out_dftpts;
    logic [5:0]    out_size;
    logic          err;

    mrd_src_pack_p4 #(.wDATA(W), .MAX_BEATS(300)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_real(in_real), .in_imag(in_imag),
        .in_dftpts(in_dftpts), .in_size(in_size),
        .in_ready(in_ready), .sink_ready(sink_ready),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_real(out_real), .out_imag(out_imag),
        .out_dftpts(out_dftpts), .out_size(out_size),
        .err(err)
    );

    typedef struct packed {
        int           cyc;
        logic         sop;
        logic         eop;
        logic         rdy;
        logic [11:0]  dft;
        logic [5:0]   sz;
        logic [4*W-1:0] re;
        logic [4*W-1:0] im;
    } beat_t;

    beat_t       q[$];
    beat_t       mon_b;
    logic [W-1:0] exp_re[$];
    logic [W-1:0] exp_im[$];
    int          cyc = 0;
    int          err_cnt = 0;
    int          clash_cnt = 0;
    int          idle_dirty = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (err === 1'b1) err_cnt++;
        if (err === 1'b1 && out_sop === 1'b1) clash_cnt++;
        if (out_valid === 1'b1) begin
            mon_b.cyc = cyc;
            mon_b.sop = out_sop;
            mon_b.eop = out_eop;
            mon_b.rdy = in_ready;
            mon_b.dft = out_dftpts;
            mon_b.sz  = out_size;
            for (int k = 0; k < 4; k++) begin
                mon_b.re[k*W +: W] = out_real[k];
                mon_b.im[k*W +: W] = out_imag[k];
            end
            q.push_back(mon_b);
        end else if ((out_real[0] | out_real[1] | out_real[2] | out_real[3] |
                      out_imag[0] | out_imag[1] | out_imag[2] | out_imag[3]) !== '0) begin
            idle_dirty++;
        end
    end

    task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic sop, input logic eop,
                                 input logic [W-1:0] re, input logic [W-1:0] im,
                                 input int dft, input int sz);
        in_valid  = v;
        in_sop    = sop;
        in_eop    = eop;
        in_real   = re;
        in_imag   = im;
        in_dftpts = 12'(dft);
        in_size   = 6'(sz);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic sendPacket(input int npts, input int dft, input int sz, input int base,
                              input int eop_at, input bit gaps, input bit record);
        logic [W-1:0] re, im;
        for (int i = 0; i < npts; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) idle(1);
            end
            re = W'(base + i);
            im = W'(262143 - 3 * base - 5 * i);
            applyStimulus(1'b1, i == 0, i == eop_at, re, im, dft, sz);
            if (record) begin
                exp_re.push_back(re);
                exp_im.push_back(im);
            end
        end
        idle(0);
    endtask

    task automatic waitBeats(input int n, input int budget);
        for (int i = 0; i < budget && q.size() < n; i++) idle(1);
        idle(4);
    endtask

    task automatic checkPacket(input string tag, input int dft, input int sz);
        int    nb;
        int    data_err, flag_err, contig_err, hdr_err, rdy_err;
        int    ix;
        beat_t bb;
        nb = dft / 4;
        data_err = 0; flag_err = 0; contig_err = 0; hdr_err = 0; rdy_err = 0;
        checkOutput({tag, "_nbeats"}, 72'(q.size()), 72'(nb));
        for (int b = 0; b < q.size() && b < nb; b++) begin
            bb = q[b];
            if (bb.sop !== (b == 0) || bb.eop !== (b == nb - 1)) flag_err++;
            if (bb.cyc != q[0].cyc + b) contig_err++;
            if (bb.dft !== 12'(dft) || bb.sz !== 6'(sz)) hdr_err++;
            if (bb.rdy !== 1'b0) rdy_err++;
            for (int k = 0; k < 4; k++) begin
                ix = 4 * b + k;
                if (ix >= exp_re.size()) data_err++;
                else if (bb.re[k*W +: W] !== exp_re[ix] || bb.im[k*W +: W] !== exp_im[ix]) data_err++;
            end
        end
        checkOutput({tag, "_data"}, 72'(data_err), 0);
        checkOutput({tag, "_sop_eop"}, 72'(flag_err), 0);
        checkOutput({tag, "_contiguous"}, 72'(contig_err), 0);
        checkOutput({tag, "_header"}, 72'(hdr_err), 0);
        checkOutput({tag, "_in_ready_low"}, 72'(rdy_err), 0);
        q.delete();
        exp_re.delete();
        exp_im.delete();
    endtask

    initial begin
        int c, e0;
        rst_n = 1'b0;
        sink_ready = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_real = '0; in_imag = '0; in_dftpts = '0; in_size = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_in_ready", 72'(in_ready), 0);
        checkOutput("rst_out_valid", 72'(out_valid), 0);
        checkOutput("rst_err", 72'(err), 0);
        checkOutput("rst_out_dftpts", 72'(out_dftpts), 0);
        rst_n = 1'b1;
        idle(2);
        checkOutput("rel_in_ready", 72'(in_ready), 1);

        // 12-point ramp, sink ready throughout
        sink_ready = 1'b1;
        sendPacket(12, 12, 3, 1, 11, 1'b0, 1'b1);
        waitBeats(3, 40);
        if (q.size() >= 3) begin
            checkOutput("t1_b0_lanes", 72'(q[0].re), {18'd4, 18'd3, 18'd2, 18'd1});
            checkOutput("t1_b2_lanes", 72'(q[2].re), {18'd12, 18'd11, 18'd10, 18'd9});
            checkOutput("t1_b0_sop", 72'(q[0].sop), 1);
            checkOutput("t1_b2_eop", 72'(q[2].eop), 1);
            checkOutput("t1_dftpts", 72'(q[0].dft), 12);
        end
        checkPacket("t1", 12, 3);
        checkOutput("t1_ready_after", 72'(in_ready), 1);

        // 1200-point packet with gaps, sink held off for 50 cycles
        sink_ready = 1'b0;
        sendPacket(1200, 1200, 50, 1, 1199, 1'b1, 1'b1);
        idle(50);
        checkOutput("t2_no_early_beats", 72'(q.size()), 0);
        checkOutput("t2_wait_in_ready", 72'(in_ready), 0);
        c = cyc;
        sink_ready = 1'b1;
        waitBeats(300, 400);
        checkOutput("t2_latency", 72'((q.size() > 0) ? (q[0].cyc - c) : 999), 3);
        checkPacket("t2", 1200, 50);

        // 24-point header with early eop, then a clean packet
        e0 = err_cnt;
        sendPacket(20, 24, 4, 500, 19, 1'b0, 1'b0);
        idle(5);
        checkOutput("t3_err_pulses", 72'(err_cnt - e0), 1);
        checkOutput("t3_no_beats", 72'(q.size()), 0);
        checkOutput("t3_in_ready", 72'(in_ready), 1);
        sendPacket(24, 24, 5, 700, 23, 1'b0, 1'b1);
        waitBeats(6, 40);
        checkPacket("t3", 24, 5);

        // Illegal point count
        e0 = err_cnt;
        sendPacket(12, 100, 6, 900, 11, 1'b0, 1'b0);
        idle(10);
        checkOutput("t4_err_pulses", 72'(err_cnt - e0), 1);
        checkOutput("t4_no_beats", 72'(q.size()), 0);
        checkOutput("t4_in_ready", 72'(in_ready), 1);

        // New sop on sample 7 of a 36-point packet
        e0 = err_cnt;
        sendPacket(6, 36, 7, 1100, -1, 1'b0, 1'b0);
        sendPacket(36, 36, 8, 1300, 35, 1'b0, 1'b1);
        waitBeats(9, 60);
        checkOutput("t5_err_pulses", 72'(err_cnt - e0), 1);
        checkPacket("t5", 36, 8);

        // Reset during beat 5 of a 60-point send
        sendPacket(60, 60, 9, 2000, 59, 1'b0, 1'b1);
        for (int i = 0; i < 60 && q.size() < 5; i++) idle(1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_out_valid", 72'(out_valid), 0);
        checkOutput("t6_out_sop_eop", 72'({out_sop, out_eop}), 0);
        checkOutput("t6_out_data", 72'({out_real[1], out_imag[2]}), 0);
        checkOutput("t6_out_hdr", 72'({out_dftpts, out_size}), 0);
        checkOutput("t6_in_ready", 72'(in_ready), 0);
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        checkOutput("t6_beats_before_reset", 72'(q.size()), 6);
        rst_n = 1'b1;
        idle(2);
        q.delete();
        exp_re.delete();
        exp_im.delete();
        sendPacket(12, 12, 10, 3000, 11, 1'b0, 1'b1);
        waitBeats(3, 40);
        checkPacket("t6_after", 12, 10);

        checkOutput("err_sop_clash", 72'(clash_cnt), 0);
        checkOutput("idle_data_zero", 72'(idle_dirty), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
